vedic_mult_pipe: RTL and testbench

- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It is the successor to the team's fixed 16x16 combinational Vedic multiplier.
- Accepts one WIDTH x WIDTH operand pair per cycle under valid/ready handshake, with per-transaction signed/unsigned mode and a passthrough tag.
- Produces a 2*WIDTH product after a fixed 3-cycle latency, with full backpressure.
- Sits between the datapath operand muxes and the accumulator/ALU result bus.

---
 rtl/vedic_pkg.sv | 18 +
 rtl/vedic_core_comb.sv | 28 ++
 rtl/vedic_mult_pipe.sv | 85 ++++++++
 tb/tb_vedic_mult_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// vedic_pkg: width helpers shared by the vedic multiplier family
package vedic_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int HALF(input int w);
    return w / 2;
  endfunction
  function automatic int PROD_W(input int w);
    return 2 * w;
  endfunction
  function automatic bit is_pow2(input int w);
    return (1 << clog2(w)) == w;
  endfunction
endpackage

// File: rtl/vedic_core_comb.sv
// vedic_core_comb: combinational W x W unsigned Urdhva-Tiryagbhyam multiplier
module vedic_core_comb
  import vedic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic [PROD_W(W)-1:0] p
);
  if (W == 2) begin : g_leaf
    logic t1, t2, t3, c1;
    assign t1 = a[1] & b[0];
    assign t2 = a[0] & b[1];
    assign t3 = a[1] & b[1];
    assign c1 = t1 & t2;
    assign p  = {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
  end else begin : g_tree
    localparam int H  = HALF(W);
    localparam int PW = PROD_W(W);
    logic [W-1:0] ll, hl, lh, hh;
    vedic_core_comb #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_core_comb #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_core_comb #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_core_comb #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
    assign p = PW'(ll) + (PW'(hl) << H) + (PW'(lh) << H) + (PW'(hh) << W);
  end
endmodule

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage signed/unsigned vedic multiplier with valid/ready,
// tag passthrough, flush and whole-pipe stall on backpressure.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_signed,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PROD_W(WIDTH)-1:0] out_p,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int H  = HALF(WIDTH);
  localparam int PW = PROD_W(WIDTH);
  if (!is_pow2(WIDTH) || WIDTH < 4 || TAG_W < 1) begin : g_bad_param
    $error("vedic_mult_pipe: WIDTH must be a power of two >= 4, TAG_W >= 1");
  end
  logic             adv, v1, v2, s1, s2;
  logic [WIDTH-1:0] ma, mb, ma1, mb1;
  logic [WIDTH-1:0] ll, hl, lh, hh, ll2, hl2, lh2, hh2;
  logic [TAG_W-1:0] t1, t2;
  logic [PW-1:0]    mag;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  // the most negative operand negates to itself, which is the right unsigned magnitude
  assign ma = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
  assign mb = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;
  vedic_core_comb #(.W(H)) u_ll (.a(ma1[H-1:0]),     .b(mb1[H-1:0]),     .p(ll));
  vedic_core_comb #(.W(H)) u_hl (.a(ma1[WIDTH-1:H]), .b(mb1[H-1:0]),     .p(hl));
  vedic_core_comb #(.W(H)) u_lh (.a(ma1[H-1:0]),     .b(mb1[WIDTH-1:H]), .p(lh));
  vedic_core_comb #(.W(H)) u_hh (.a(ma1[WIDTH-1:H]), .b(mb1[WIDTH-1:H]), .p(hh));
  assign mag = PW'(ll2) + (PW'(hl2) << H) + (PW'(lh2) << H) + (PW'(hh2) << WIDTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1      <= 1'b0;
      ma1     <= '0;
      mb1     <= '0;
      t1      <= '0;
      s2      <= 1'b0;
      t2      <= '0;
      ll2     <= '0;
      hl2     <= '0;
      lh2     <= '0;
      hh2     <= '0;
      out_p   <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s1      <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      ma1     <= ma;
      mb1     <= mb;
      t1      <= in_tag;
      s2      <= s1;
      t2      <= t1;
      ll2     <= ll;
      hl2     <= hl;
      lh2     <= lh;
      hh2     <= hh;
      out_p   <= s2 ? -mag : mag;
      out_tag <= t2;
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: scoreboard bench for vedic_mult_pipe at WIDTH 16, 8 and 32
module tb_vedic_mult_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid, in_ready, in_signed, flush, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_p;
  logic v8, r8, s8, f8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] p8;
  logic v32, r32, s32, f32, ov32, or32;
  logic [31:0] a32, b32;
  logic [3:0]  t32, ot32;
  logic [63:0] p32;
  int checks = 0, errors = 0, cyc = 0;
  bit lat_on = 1'b1;
  typedef struct { logic [31:0] p; logic [3:0] tag; int cyc; bit lat; } exp_t;
  exp_t q[$];
  exp_t me;
  logic [63:0] q8[$], q32[$];
  logic [63:0] e8, e32;

  vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag));
  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_signed(s8), .in_tag(t8),
    .flush(f8), .out_valid(ov8), .out_ready(or8),
    .out_p(p8), .out_tag(ot8));
  vedic_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_signed(s32), .in_tag(t32),
    .flush(f32), .out_valid(ov32), .out_ready(or32),
    .out_p(p32), .out_tag(ot32));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sp;
    logic [31:0] up;
    sp = $signed(a) * $signed(b);
    up = {16'b0, a} * {16'b0, b};
    return s ? sp : up;
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
      else begin
        me = q.pop_front();
        chk("out_p", out_p, me.p);
        chk("out_tag", out_tag, me.tag);
        if (me.lat) chk("latency", cyc, me.cyc + 3);
      end
    end
  always @(negedge clk)
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) chk("w8_unexpected_out_valid", ov8, 0);
      else begin
        e8 = q8.pop_front();
        chk("w8_out_p", p8, e8);
        chk("w8_out_tag", ot8, 4'h5);
      end
    end
  always @(negedge clk)
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) chk("w32_unexpected_out_valid", ov32, 0);
      else begin
        e32 = q32.pop_front();
        chk("w32_out_p", p32, e32);
        chk("w32_out_tag", ot32, 4'hA);
      end
    end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [3:0] t, input logic [31:0] e, input bit push);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout_in_ready", in_ready, 1);
    else if (push) q.push_back('{e, t, cyc, lat_on});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic smoke8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", r8, 1);
    q8.push_back(64'(e));
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask

  task automatic smoke32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
    a32 = a; b32 = b; s32 = s; v32 = 1'b1;
    @(negedge clk);
    chk("w32_in_ready", r32, 1);
    q32.push_back(e);
    @(posedge clk);
    #1 v32 = 1'b0;
  endtask

  initial begin
    in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; flush = 0; out_ready = 1;
    v8 = 0; a8 = 0; b8 = 0; s8 = 0; t8 = 4'h5; f8 = 0; or8 = 1;
    v32 = 0; a32 = 0; b32 = 0; s32 = 0; t32 = 4'hA; f32 = 0; or32 = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_tag", out_tag, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    // directed corner products, hand-computed
    send(16'hFFFF, 16'hFFFF, 0, 4'h3, 32'hFFFE0001, 1);
    send(16'hFFFF, 16'hFFFF, 1, 4'h4, 32'h00000001, 1);
    send(16'h8000, 16'h8000, 1, 4'h5, 32'h40000000, 1);
    send(16'h8000, 16'h0001, 1, 4'h6, 32'hFFFF8000, 1);
    send(16'h8000, 16'h0001, 0, 4'h7, 32'h00008000, 1);
    send(16'h0000, 16'h8000, 1, 4'h8, 32'h00000000, 1);
    send(16'hFFFF, 16'h0000, 1, 4'h9, 32'h00000000, 1);
    send(16'h1234, 16'h0010, 0, 4'hA, 32'h00012340, 1);
    send(16'hFFFE, 16'h0003, 1, 4'hB, 32'hFFFFFFFA, 1);
    // mixed-mode random stream, back to back
    for (int i = 0; i < 100; i++) begin
      logic [15:0] a, b;
      logic s;
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      send(a, b, s, 4'(i), model(a, b, s), 1);
    end
    // backpressure: 5-cycle stall with inputs still offered
    lat_on = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(16'(i + 3), 16'h0101, 0, 4'(i), model(16'(i + 3), 16'h0101, 0), 1);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_p", out_p, q.size() != 0 ? q[0].p : 'x);
          chk("stall_out_tag", out_tag, q.size() != 0 ? q[0].tag : 'x);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("stall_drained", q.size(), 0);
    lat_on = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    // flush with three operations in flight; none of them may emerge
    send(16'd11, 16'd11, 0, 4'h1, 0, 0);
    send(16'd12, 16'd12, 0, 4'h2, 0, 0);
    send(16'd13, 16'd13, 0, 4'h3, 0, 0);
    flush = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1; in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5; in_signed = 1'b0; in_tag = 4'hE;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    send(16'd7, 16'd6, 0, 4'hC, 32'd42, 1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("flush_next_done", q.size(), 0);
    // asynchronous reset mid-stream
    @(posedge clk);
    #1;
    send(16'h0102, 16'h0304, 0, 4'h1, 32'h00030A08, 1);
    send(16'h0005, 16'h0006, 0, 4'h2, 32'h0000001E, 1);
    send(16'h0007, 16'h0008, 0, 4'h3, 32'h00000038, 1);
    send(16'h0009, 16'h000A, 0, 4'h4, 32'h0000005A, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_p", out_p, 0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
    end
    // smoke at other widths
    @(posedge clk);
    #1;
    smoke8(8'hFF, 8'hFF, 0, 16'hFE01);
    smoke8(8'h80, 8'h80, 1, 16'h4000);
    smoke8(8'hFF, 8'h01, 1, 16'hFFFF);
    smoke32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001);
    smoke32(32'h80000000, 32'h00000001, 1, 64'hFFFFFFFF80000000);
    smoke32(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'h0000000000000001);
    for (int i = 0; i < 20 && (q.size() + q8.size() + q32.size()) != 0; i++) @(negedge clk);
    chk("final_drain", q.size() + q8.size() + q32.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
